retire_trace_buffer: RTL

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

---
 rtl/riscv_pkg.sv | 19 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/retire_trace_buffer.sv | 87 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, default trace depth and the
// retire trace record carried through the trace buffer.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int TRACE_DEPTH = 16;

  typedef struct packed {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } trace_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// The head entry is presented combinationally whenever count is non-zero.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     push_ok_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop_ok;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    full      = 1'b0;
    pop_ok    = 1'b0;
    push_ok_o = 1'b0;
    full      = (count == CW'(DEPTH));
    pop_ok    = pop_i && (count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_ok_o = push_i && (!full || pop_ok);
  end

  // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok_o && !flush_i) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
      if (push_ok_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)    rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok_o, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data_o = mem[rd_ptr];
  assign count_o    = count;

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: stamps each retired instruction with a sequence number,
// queues it in a FWFT FIFO and counts records lost to a full buffer.
module retire_trace_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH        = TRACE_DEPTH,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output trace_rec_t               out_rec_o,
  output logic                     almost_full_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int RW = $bits(trace_rec_t);
  localparam logic [LW-1:0] AFULL_LVL = LW'(DEPTH - AFULL_MARGIN);

  logic [31:0]   seq_q;
  trace_rec_t    in_rec;
  logic [RW-1:0] head_bits;
  logic          push_ok;
  logic [LW-1:0] level;

  always_comb begin
    in_rec          = '0;
    in_rec.seq      = seq_q;
    in_rec.pc       = pc_i;
    in_rec.instr    = instr_i;
    in_rec.reg_addr = reg_addr_i;
    in_rec.reg_data = reg_data_i;
    in_rec.mem_addr = mem_addr_i;
    in_rec.mem_data = mem_data_i;
    in_rec.mem_wrt  = mem_wrt_i;
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (update_i),
    .push_data_i (in_rec),
    .pop_i       (out_ready_i),
    .pop_data_o  (head_bits),
    .push_ok_o   (push_ok),
    .count_o     (level)
  );

  // Sequence advances on every retire, kept or dropped, so gaps reveal losses.
  // A flush discards the cycle's record deliberately; that is not a drop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else if (update_i) begin
      seq_q <= seq_q + 1'b1;
      if (!push_ok && !flush_i) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  assign out_rec_o     = trace_rec_t'(head_bits);
  assign out_valid_o   = (level != '0);
  assign almost_full_o = (level >= AFULL_LVL);
  assign level_o       = level;

endmodule
